// File: rtl/rnn_fixed_pkg.sv
// Shared fixed-point constants and FSM state encoding for the RNN gate datapath.
// Reused by the pre-activation, sigmoid and tanh stages.
package rnn_fixed_pkg;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned PROD_W    = 64;
  localparam int unsigned FRAC_BITS = 15;

  localparam logic [DATA_W-1:0] Q_MAX     = 32'h7FFF_FFFF;
  localparam logic [DATA_W-1:0] Q_MIN     = 32'h8000_0000;
  localparam logic [DATA_W-1:0] Q1_15_ONE = 32'd32768;

  typedef enum logic [1:0] {
    ACCUM,
    DRAIN,
    FINAL,
    OUT
  } state_t;

endpackage

// File: rtl/rnn_gate_preact_if.sv
// Streaming handshake bundle for the gate pre-activation stage:
// (x, w, bias) beats in, one saturated Q17.15 result out.
interface rnn_gate_preact_if;
  import rnn_fixed_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] x_in;
  logic [DATA_W-1:0] w_in;
  logic [DATA_W-1:0] bias_in;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] y_out;
  logic              sat_out;

  modport master (
    output in_valid, x_in, w_in, bias_in, out_ready,
    input  in_ready, out_valid, y_out, sat_out
  );

  modport slave (
    input  in_valid, x_in, w_in, bias_in, out_ready,
    output in_ready, out_valid, y_out, sat_out
  );

endinterface

// File: rtl/fx_shift_sat.sv
// Drops FRAC_BITS from a wide signed Q.30 sum (floor, no rounding) and clips
// the result to the Q17.15 range, flagging when clipping occurred.
module fx_shift_sat
  import rnn_fixed_pkg::*;
#(
  parameter int unsigned ACC_W = 72
) (
  input  logic signed [ACC_W-1:0]  sum,
  output logic        [DATA_W-1:0] y_c,
  output logic                     sat_c
);

  logic signed [ACC_W-1:0]      shifted;
  logic        [ACC_W-DATA_W:0] upper;

  // Value fits in 32 bits only if every bit from bit 31 upward is a sign copy.
  always_comb begin
    shifted = sum >>> FRAC_BITS;
    upper   = shifted[ACC_W-1:DATA_W-1];
    y_c     = shifted[DATA_W-1:0];
    sat_c   = 1'b0;
    if (!((&upper) || (~|upper))) begin
      sat_c = 1'b1;
      y_c   = shifted[ACC_W-1] ? Q_MIN : Q_MAX;
    end
  end

endmodule

// File: rtl/rnn_gate_preact.sv
// Sequential dot product plus bias feeding the gate sigmoid: N_TERMS
// Q17.15 products accumulated at full precision, then floored and saturated.
module rnn_gate_preact
  import rnn_fixed_pkg::*;
#(
  parameter int unsigned N_TERMS = 8,
  parameter int unsigned ACC_W   = 72
) (
  input  logic               clk,
  input  logic               rst,
  rnn_gate_preact_if.slave   bus
);

  localparam int unsigned CNT_W = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;

  state_t                    state;
  logic [CNT_W-1:0]          count;
  logic signed [PROD_W-1:0]  prod_reg;
  logic                      prod_vld;
  logic signed [ACC_W-1:0]   acc;
  logic [DATA_W-1:0]         bias_reg;
  logic                      in_ready;
  logic                      out_valid;
  logic [DATA_W-1:0]         y_out;
  logic                      sat_out;

  logic                      accept_c;
  logic                      last_c;
  logic signed [ACC_W-1:0]   sum_c;
  logic [DATA_W-1:0]         y_c;
  logic                      sat_c;

  assign accept_c = bus.in_valid && in_ready;
  assign last_c   = (count == CNT_W'(N_TERMS - 1));

  // Bias is aligned to the Q.30 product scale before the final add.
  assign sum_c = acc + (ACC_W'($signed(bias_reg)) <<< FRAC_BITS);

  fx_shift_sat #(
    .ACC_W (ACC_W)
  ) u_shift_sat (
    .sum   (sum_c),
    .y_c   (y_c),
    .sat_c (sat_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ACCUM;
      count     <= '0;
      prod_reg  <= '0;
      prod_vld  <= 1'b0;
      acc       <= '0;
      bias_reg  <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      y_out     <= '0;
      sat_out   <= 1'b0;
    end else begin
      // One-stage multiply pipeline; the product lands in acc on the next edge.
      prod_vld <= accept_c;
      if (accept_c) begin
        prod_reg <= PROD_W'($signed(bus.x_in)) * PROD_W'($signed(bus.w_in));
      end
      if (prod_vld) begin
        acc <= acc + ACC_W'(prod_reg);
      end

      case (state)
        ACCUM: begin
          if (accept_c) begin
            if (count == '0) begin
              bias_reg <= bus.bias_in;
            end
            if (last_c) begin
              count    <= '0;
              in_ready <= 1'b0;
              state    <= DRAIN;
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        DRAIN: begin
          state <= FINAL;
        end
        FINAL: begin
          y_out     <= y_c;
          sat_out   <= sat_c;
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (bus.out_ready) begin
            out_valid <= 1'b0;
            acc       <= '0;
            in_ready  <= 1'b1;
            state     <= ACCUM;
          end
        end
        default: begin
          state <= ACCUM;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.y_out     = y_out;
  assign bus.sat_out   = sat_out;

endmodule

// File: tb/tb_rnn_gate_preact.sv
// Directed bench for rnn_gate_preact with N_TERMS=4: arithmetic, floor,
// saturation, bubbles, output backpressure and asynchronous reset.
module tb_rnn_gate_preact;
  import rnn_fixed_pkg::*;

  typedef logic [31:0] vec4_t [4];

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rnn_gate_preact_if bus ();

  rnn_gate_preact #(
    .N_TERMS (4),
    .ACC_W   (72)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Feeds one 4-beat vector starting at a negedge; returns the cycle of the last accepting edge.
  task automatic send_vector(input vec4_t xs, input vec4_t ws, input logic [31:0] bias,
                             input bit bubbles, output int last_edge);
    for (int i = 0; i < 4; i++) begin
      int budget;
      bus.in_valid = 1'b1;
      bus.x_in     = xs[i];
      bus.w_in     = ws[i];
      bus.bias_in  = (i == 0) ? bias : 32'h1234_5678;
      budget = 0;
      while (!bus.in_ready && budget < 20) begin
        @(negedge clk);
        budget++;
      end
      if (!bus.in_ready) begin
        tests++;
        fails++;
        $display("FAIL send_beat%0d: in_ready=%0b, required 1 within 20 cycles", i, bus.in_ready);
      end
      @(posedge clk);
      @(negedge clk);
      last_edge = cyc;
      bus.in_valid = 1'b0;
      if (bubbles) begin
        @(posedge clk);
        @(negedge clk);
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_result(input int start, output logic [31:0] y, output logic s,
                             output int lat);
    int budget;
    budget = 0;
    while (!bus.out_valid && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    if (!bus.out_valid) begin
      tests++;
      fails++;
      $display("FAIL wait_out_valid: out_valid=%0b, required 1 within 20 cycles", bus.out_valid);
    end
    y   = bus.y_out;
    s   = bus.sat_out;
    lat = cyc - start;
  endtask

  task automatic ack_result();
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic fill(input logic [31:0] a0, a1, a2, a3, output vec4_t v);
    v[0] = a0; v[1] = a1; v[2] = a2; v[3] = a3;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if (bus.out_valid !== 1'b0) begin
      fails++; $display("FAIL reset_out_valid: got %0b, required 0", bus.out_valid);
    end
    tests++;
    if (bus.y_out !== 32'h0) begin
      fails++; $display("FAIL reset_y_out: got %h, required 00000000", bus.y_out);
    end
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (bus.in_ready !== 1'b1) begin
      fails++; $display("FAIL reset_in_ready: got %0b, required 1", bus.in_ready);
    end
    tests++;
    if (bus.sat_out !== 1'b0) begin
      fails++; $display("FAIL reset_sat_out: got %0b, required 0", bus.sat_out);
    end
  endtask

  task automatic test_basic();
    vec4_t xs, ws;
    logic [31:0] y; logic s; int k, lat;
    fill(32768, 32768, 32768, 32768, xs);
    fill(16384, 16384, 16384, 16384, ws);
    send_vector(xs, ws, 32'd0, 1'b0, k);
    wait_result(k, y, s, lat);
    tests++;
    if (y !== 32'd65536) begin
      fails++; $display("FAIL basic_y: got %0d, required 65536", $signed(y));
    end
    tests++;
    if (s !== 1'b0) begin
      fails++; $display("FAIL basic_sat: got %0b, required 0", s);
    end
    tests++;
    if (lat != 2) begin
      fails++; $display("FAIL basic_latency: got %0d edges, required 2", lat);
    end
    ack_result();
    tests++;
    if (bus.out_valid !== 1'b0) begin
      fails++; $display("FAIL basic_out_valid_drop: got %0b, required 0", bus.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    vec4_t xs, ws;
    logic [31:0] y; logic s; int k, lat;
    fill(-32768, -32768, -32768, -32768, xs);
    fill(32768, 32768, 32768, 32768, ws);
    send_vector(xs, ws, 32'd16384, 1'b0, k);
    wait_result(k, y, s, lat);
    tests++;
    if (y !== 32'hFFFE_4000) begin
      fails++; $display("FAIL b2b_first_y: got %0d, required -114688", $signed(y));
    end
    ack_result();
    tests++;
    if (bus.in_ready !== 1'b1) begin
      fails++; $display("FAIL b2b_in_ready_after_ack: got %0b, required 1", bus.in_ready);
    end
    send_vector(xs, ws, 32'd0, 1'b0, k);
    wait_result(k, y, s, lat);
    tests++;
    if (y !== 32'hFFFE_0000) begin
      fails++; $display("FAIL b2b_second_y: got %0d, required -131072", $signed(y));
    end
    ack_result();
  endtask

  task automatic test_truncation();
    vec4_t xs, ws;
    logic [31:0] y; logic s; int k, lat;
    fill(1, 0, 0, 0, xs);
    fill(1, 0, 0, 0, ws);
    send_vector(xs, ws, 32'd0, 1'b0, k);
    wait_result(k, y, s, lat);
    tests++;
    if (y !== 32'd0) begin
      fails++; $display("FAIL trunc_pos_y: got %0d, required 0", $signed(y));
    end
    ack_result();
    fill(32'hFFFF_FFFF, 0, 0, 0, xs);
    send_vector(xs, ws, 32'd0, 1'b0, k);
    wait_result(k, y, s, lat);
    tests++;
    if (y !== 32'hFFFF_FFFF) begin
      fails++; $display("FAIL trunc_neg_y: got %h, required ffffffff", y);
    end
    ack_result();
  endtask

  task automatic test_saturation();
    vec4_t xs, ws;
    logic [31:0] y; logic s; int k, lat;
    fill(536870912, 536870912, 536870912, 536870912, xs);
    fill(536870912, 536870912, 536870912, 536870912, ws);
    send_vector(xs, ws, 32'd0, 1'b0, k);
    wait_result(k, y, s, lat);
    tests++;
    if (y !== 32'h7FFF_FFFF) begin
      fails++; $display("FAIL sat_pos_y: got %h, required 7fffffff", y);
    end
    tests++;
    if (s !== 1'b1) begin
      fails++; $display("FAIL sat_pos_flag: got %0b, required 1", s);
    end
    ack_result();
    fill(-536870912, -536870912, -536870912, -536870912, xs);
    send_vector(xs, ws, 32'd0, 1'b0, k);
    wait_result(k, y, s, lat);
    tests++;
    if (y !== 32'h8000_0000) begin
      fails++; $display("FAIL sat_neg_y: got %h, required 80000000", y);
    end
    tests++;
    if (s !== 1'b1) begin
      fails++; $display("FAIL sat_neg_flag: got %0b, required 1", s);
    end
    ack_result();
  endtask

  task automatic test_bubbles();
    vec4_t xs, ws;
    logic [31:0] y; logic s; int k, lat;
    fill(32768, 32768, 32768, 32768, xs);
    fill(16384, 16384, 16384, 16384, ws);
    send_vector(xs, ws, 32'd0, 1'b1, k);
    wait_result(k, y, s, lat);
    tests++;
    if (y !== 32'd65536) begin
      fails++; $display("FAIL bubbles_y: got %0d, required 65536", $signed(y));
    end
    tests++;
    if (s !== 1'b0) begin
      fails++; $display("FAIL bubbles_sat: got %0b, required 0", s);
    end
    ack_result();
  endtask

  task automatic test_backpressure();
    vec4_t xs, ws;
    logic [31:0] y; logic s; int k, lat;
    fill(32768, 32768, 32768, 32768, xs);
    fill(16384, 16384, 16384, 16384, ws);
    send_vector(xs, ws, 32'd0, 1'b0, k);
    wait_result(k, y, s, lat);
    // Offer a stray beat while the result is stalled; it must not be taken.
    bus.in_valid = 1'b1;
    bus.x_in     = 32'd32768;
    bus.w_in     = 32'd32768;
    bus.bias_in  = 32'd32768;
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (bus.out_valid !== 1'b1 || bus.y_out !== 32'd65536 || bus.sat_out !== 1'b0) begin
        fails++;
        $display("FAIL stall_hold%0d: valid=%0b y=%0d sat=%0b, required 1/65536/0",
                 i, bus.out_valid, $signed(bus.y_out), bus.sat_out);
      end
      tests++;
      if (bus.in_ready !== 1'b0) begin
        fails++; $display("FAIL stall_in_ready%0d: got %0b, required 0", i, bus.in_ready);
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    ack_result();
    send_vector(xs, ws, 32'd0, 1'b0, k);
    wait_result(k, y, s, lat);
    tests++;
    if (y !== 32'd65536) begin
      fails++; $display("FAIL stall_next_y: got %0d, required 65536", $signed(y));
    end
    ack_result();
  endtask

  task automatic test_reset_mid();
    vec4_t xs, ws;
    logic [31:0] y; logic s; int k, lat;
    // y_out still holds 65536 from the previous vector, so the clear is visible.
    for (int i = 0; i < 2; i++) begin
      bus.in_valid = 1'b1;
      bus.x_in     = 32'd32768;
      bus.w_in     = 32'd32768;
      bus.bias_in  = 32'd32768;
      @(posedge clk);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    tests++;
    if (bus.out_valid !== 1'b0) begin
      fails++; $display("FAIL rstmid_out_valid: got %0b, required 0", bus.out_valid);
    end
    tests++;
    if (bus.y_out !== 32'd0) begin
      fails++; $display("FAIL rstmid_y_out: got %0d, required 0", $signed(bus.y_out));
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    fill(32768, 32768, 32768, 32768, xs);
    fill(16384, 16384, 16384, 16384, ws);
    send_vector(xs, ws, 32'd0, 1'b0, k);
    wait_result(k, y, s, lat);
    tests++;
    if (y !== 32'd65536) begin
      fails++; $display("FAIL rstmid_fresh_y: got %0d, required 65536", $signed(y));
    end
    ack_result();
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.x_in      = '0;
    bus.w_in      = '0;
    bus.bias_in   = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_truncation();
    test_saturation();
    test_bubbles();
    test_backpressure();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rnn_gate_preact.md
Name: rnn_gate_preact

Overview:
- Sequential dot-product stage directly upstream of the gate sigmoid.
- Streams N_TERMS (input, weight) pairs in Q17.15, multiplies and accumulates them at full precision, then adds a per-vector bias.
- Rescales and saturates the sum to a Q17.15 pre-activation word, which feeds the sigmoid's x input.
- Valid/ready handshake on both sides; one result per vector.

Parameters:
- N_TERMS, 8, number of products per vector (>=1).
- ACC_W, 72, accumulator width in bits (Q34.30 plus guard bits; must be >= 64 + clog2(N_TERMS) + 1).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  beat valid.
- in_ready  out  1  block can accept a beat.
- x_in  in  32  signed Q17.15 input element.
- w_in  in  32  signed Q17.15 weight element.
- bias_in  in  32  signed Q17.15 bias; sampled on the first beat of each vector.
- out_valid  out  1  pre-activation result valid.
- out_ready  in  1  downstream accepts result.
- y_out  out  32  signed Q17.15 pre-activation (sigmoid x).
- sat_out  out  1  y_out was clipped; qualified by out_valid.

Behaviour:
- Reset (async, active-high): state=ACCUM; beat count=0; acc=0; prod_vld=0; y_out=0; sat_out=0; out_valid=0. in_ready=1 after reset release.
- States:
  - ACCUM: in_ready=1. A beat is accepted when in_valid && in_ready at a rising edge. Count increments; prod_reg <= x_in*w_in (64-bit signed Q34.30); prod_vld<=1.
  - When the accepted beat is number N_TERMS-1 (0-based), count wraps to 0 and state goes to DRAIN.
  - Bubbles (in_valid=0) are allowed anywhere in a vector.
  - Pipeline: on every edge where prod_vld=1, acc <= acc + sign-extended prod_reg.
  - DRAIN (1 cycle): in_ready=0; the final product is added to acc. Next state is FINAL.
  - FINAL (1 cycle): in_ready=0.
    - sum = acc + (bias_reg sign-extended <<< 15).
    - r = sum >>> 15: arithmetic shift, truncation toward -inf, no rounding.
    - If r > 2^31-1: y_out=0x7FFF_FFFF, sat_out=1.
    - If r < -2^31: y_out=0x8000_0000, sat_out=1.
    - Otherwise: y_out=r[31:0], sat_out=0.
    - out_valid<=1; next state is OUT.
  - OUT: in_ready=0; y_out and sat_out held stable while out_valid=1 && !out_ready. On out_valid && out_ready: out_valid<=0, acc<=0, state=ACCUM. The next beat may be accepted in the cycle after the result handshake.
- Latency: last beat accepted at edge k, acc final at edge k+1, out_valid=1 after edge k+2. Minimum vector period is N_TERMS+3 cycles.
- bias_reg is loaded when a beat is accepted with count==0; bias_in is ignored on all other beats.
- Arithmetic: all signed; no intermediate overflow is possible given the ACC_W rule. Saturation applies only at the output.
- in_valid while in_ready=0: ignored, no state change.
- out_ready asserted while out_valid=0: ignored.
- Reset mid-vector or mid-OUT: partial accumulation, bias_reg and pending result are discarded; all registers return to reset values.

Decomposition:
- Shared package rnn_fixed_pkg holds:
  - FRAC_BITS=15.
  - Q17.15 MAX (32'h7FFF_FFFF) and MIN (32'h8000_0000).
  - Q1.15 ONE (32768).
  - State enum {ACCUM, DRAIN, FINAL, OUT}.
  - These are reused by the sigmoid and future tanh stages.
- One natural sub-module, fx_shift_sat: purely combinational. Takes an ACC_W signed sum, produces the 32-bit truncated and saturated Q17.15 value plus a sat flag. Shared with other accumulating stages.

Test Plan:
- N_TERMS=4; 4 beats of x=32768 (1.0), w=16384 (0.5), bias=0 -> y_out=65536 (2.0), sat_out=0, out_valid exactly 2 edges after the 4th beat's accepting edge.
- 4 beats of x=-32768, w=32768, bias=16384 (0.5) -> y_out=-114688 (-3.5); a second back-to-back vector with bias=0 -> -131072, proving acc was cleared.
- Truncation: beat0 x=1, w=1, remaining beats zero, bias=0 -> y_out=0. Then beat0 x=-1, w=1 -> y_out=-1 (0xFFFF_FFFF), floor not toward zero.
- Saturation: 4 beats x=w=536870912 (16384.0), bias=0 -> y_out=0x7FFF_FFFF, sat_out=1. With x negated -> 0x8000_0000, sat_out=1.
- Backpressure and bubbles:
  - in_valid toggled 1,0,1,0,... across a vector gives the same result as the contiguous case.
  - out_ready held low 5 cycles after out_valid -> y_out and sat_out stable, in_ready=0, offered beats not consumed.
- Reset mid-vector: assert rst after 2 accepted beats -> out_valid=0, y_out=0 immediately (async). After release, a fresh 4-beat vector (scenario 1 values) -> y_out=65536.
